// File: rtl/cgra_config_loader.sv
// cgra_config_loader: streams a CGRA configuration image from config memory
// to the PE configuration bus.
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle load request, ignored while busy
//   base_addr         byte address of word 0 (low 3 bits forced to 0)
//   word_cnt          number of 8-byte words in the image
//   busy, done        status; done pulses for one cycle at image end
//   mem_addr/mem_ren  registered read request (one ren cycle per word)
//   mem_rdata/valid   read return, valid one cycle after mem_ren
//   pe_cfg_valid/ready/data/id/last  PE config bus, valid/ready handshake
module cgra_config_loader #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_PE     = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned PE_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic                  pe_cfg_valid,
  input  logic                  pe_cfg_ready,
  output logic [DATA_WIDTH-1:0] pe_cfg_data,
  output logic [PE_W-1:0]       pe_cfg_id,
  output logic                  pe_cfg_last
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  typedef struct packed {
    logic                  last;
    logic [PE_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } cfg_word_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  issued;
  logic [CNT_WIDTH-1:0]  push_cnt;
  logic [PE_W-1:0]       push_id;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [ADDR_WIDTH-1:0] base_aligned;
  logic [1:0]            inflight, inflight_n;
  logic [1:0]            count, count_n;
  cfg_word_t             ent0, ent1, ent0_n, ent1_n;
  cfg_word_t             word_in;
  logic [2:0]            occ;
  logic                  start_load, issue, issue_any, push, pop;

  assign base_aligned = base_addr & ~ADDR_WIDTH'(7);

  // Head entry drives the bus; empty entries are kept at zero.
  assign pe_cfg_data = ent0.data;
  assign pe_cfg_id   = ent0.id;
  assign pe_cfg_last = ent0.last;

  // Next-state, issue decision and FIFO update.
  always_comb begin
    state_next = state;
    start_load = 1'b0;
    issue      = 1'b0;
    ent0_n     = ent0;
    ent1_n     = ent1;
    count_n    = count;

    pop  = pe_cfg_valid & pe_cfg_ready;
    // A return with no read outstanding (e.g. right after reset) is dropped.
    push = mem_valid & (inflight != 2'd0);

    // Every read not yet accepted on the PE bus holds a slot, so a
    // returning word always finds room in the 2-entry FIFO.
    occ = 3'(count) + 3'(inflight) - 3'(pop);

    word_in.data = mem_rdata;
    word_in.id   = push_id;
    word_in.last = (push_cnt == cnt_q - CNT_WIDTH'(1));

    unique case (state)
      IDLE: begin
        if (start) begin
          if (word_cnt == '0) begin
            state_next = DONE;
          end else begin
            state_next = LOAD;
            start_load = 1'b1;
          end
        end
      end
      LOAD: begin
        issue = (issued < cnt_q) && (occ < 3'd2);
        if (pop && ent0.last) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    issue_any  = start_load | issue;
    inflight_n = inflight + 2'(issue_any) - 2'(push);

    if (push && !pop) begin
      if (count == 2'd0) ent0_n = word_in;
      else               ent1_n = word_in;
      count_n = count + 2'd1;
    end else if (!push && pop) begin
      ent0_n  = ent1;
      ent1_n  = '0;
      count_n = count - 2'd1;
    end else if (push && pop) begin
      if (count == 2'd1) begin
        ent0_n = word_in;
      end else begin
        ent0_n = ent1;
        ent1_n = word_in;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_ren      <= 1'b0;
      mem_addr     <= '0;
      nxt_addr     <= '0;
      cnt_q        <= '0;
      issued       <= '0;
      push_cnt     <= '0;
      push_id      <= '0;
      inflight     <= '0;
      count        <= '0;
      ent0         <= '0;
      ent1         <= '0;
      pe_cfg_valid <= 1'b0;
    end else begin
      busy         <= (state_next != IDLE);
      done         <= (state_next == DONE);
      mem_ren      <= issue_any;
      inflight     <= inflight_n;
      count        <= count_n;
      ent0         <= ent0_n;
      ent1         <= ent1_n;
      pe_cfg_valid <= (count_n != 2'd0);

      if (start_load) begin
        cnt_q    <= word_cnt;
        issued   <= CNT_WIDTH'(1);
        push_cnt <= '0;
        push_id  <= '0;
        mem_addr <= base_aligned;
        nxt_addr <= base_aligned + ADDR_WIDTH'(8);
      end else if (issue) begin
        issued   <= issued + CNT_WIDTH'(1);
        mem_addr <= nxt_addr;
        nxt_addr <= nxt_addr + ADDR_WIDTH'(8);
      end

      if (push) begin
        push_cnt <= push_cnt + CNT_WIDTH'(1);
        push_id  <= (push_id == PE_W'(NUM_PE - 1)) ? '0 : push_id + PE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cgra_config_loader.sv
// Testbench for cgra_config_loader: memory responder, random backpressure,
// and a queue-based reference of the expected read addresses and words.
module tb_cgra_config_loader;

  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 32;
  localparam int unsigned NPE = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned PW  = 2;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] base_addr, mem_addr;
  logic [CW-1:0] word_cnt;
  logic          busy, done, mem_ren;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_rdata;
  logic          pe_cfg_valid, pe_cfg_ready, pe_cfg_last;
  logic [DW-1:0] pe_cfg_data;
  logic [PW-1:0] pe_cfg_id;

  always #5 clk = ~clk;

  cgra_config_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PE(NPE), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .pe_cfg_valid(pe_cfg_valid), .pe_cfg_ready(pe_cfg_ready),
    .pe_cfg_data(pe_cfg_data), .pe_cfg_id(pe_cfg_id), .pe_cfg_last(pe_cfg_last)
  );

  logic [31:0] salt;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ salt, a * 32'h9E37_79B1};
  endfunction

  // Config memory: data returned one cycle after the read enable.
  always @(posedge clk) begin
    mem_valid <= mem_ren;
    mem_rdata <= mem_word(mem_addr);
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [PW-1:0] id;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit            m_busy = 1'b0, m_done = 1'b0;
  int            reads_seen = 0, hs_done = 0, cyc = 0, first_ren_cyc = -1;
  bit            got_first_valid = 1'b1;
  logic          prev_valid = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [PW-1:0] prev_id = '0;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; at the falling edge compare the DUT against the model.
  task automatic tick();
    bit    hs, acc, e_last, m_done_n, m_busy_n;
    word_t e;
    logic [AW-1:0] a0, a;
    @(negedge clk);
    cyc++;
    if (rst) begin
      check("rst_outputs",
            128'({busy, done, mem_ren, mem_addr, pe_cfg_valid, pe_cfg_data, pe_cfg_id, pe_cfg_last}),
            128'(0));
      exp_q.delete();
      addr_q.delete();
      m_busy = 1'b0; m_done = 1'b0;
      reads_seen = 0; hs_done = 0; got_first_valid = 1'b1;
    end else begin
      hs     = prev_valid && pe_cfg_ready;
      acc    = start && !m_busy;
      e_last = 1'b0;
      if (hs) begin
        check("word_avail", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", 128'(prev_data), 128'(e.data));
          check("id",   128'(prev_id),   128'(e.id));
          check("last", 128'(prev_last), 128'(e.last));
          e_last = e.last;
        end
        hs_done++;
      end
      m_done_n = (hs && e_last) || (acc && word_cnt == '0);
      m_busy_n = acc ? 1'b1 : (m_done ? 1'b0 : m_busy);

      if (acc) begin
        a0 = base_addr & ~32'h7;
        for (int i = 0; i < int'(word_cnt); i++) begin
          a = a0 + AW'(8 * i);
          addr_q.push_back(a);
          e.data = mem_word(a);
          e.id   = PW'(i % NPE);
          e.last = (i == int'(word_cnt) - 1);
          exp_q.push_back(e);
        end
        reads_seen = 0; hs_done = 0; first_ren_cyc = -1;
        got_first_valid = (word_cnt == '0);
        if (word_cnt != '0) check("first_ren", 128'(mem_ren), 128'(1));
      end

      if (mem_ren) begin
        check("ren_expected", 128'(addr_q.size() != 0), 128'(1));
        if (addr_q.size() != 0) check("mem_addr", 128'(mem_addr), 128'(addr_q.pop_front()));
        reads_seen++;
        if (first_ren_cyc < 0) first_ren_cyc = cyc;
      end

      if (pe_cfg_valid && !got_first_valid) begin
        got_first_valid = 1'b1;
        check("first_valid_lat", 128'(cyc - first_ren_cyc), 128'(2));
      end

      if (prev_valid && !pe_cfg_ready)
        check("hold", 128'({pe_cfg_valid, pe_cfg_data, pe_cfg_id, pe_cfg_last}),
              128'({1'b1, prev_data, prev_id, prev_last}));

      check("occupancy", 128'((reads_seen - hs_done) <= 2), 128'(1));
      check("last_needs_valid", 128'(pe_cfg_last & ~pe_cfg_valid), 128'(0));
      check("done", 128'(done), 128'(m_done_n));
      check("busy", 128'(busy), 128'(m_busy_n));
      m_done = m_done_n;
      m_busy = m_busy_n;
    end
    prev_valid = pe_cfg_valid;
    prev_data  = pe_cfg_data;
    prev_id    = pe_cfg_id;
    prev_last  = pe_cfg_last;
  endtask

  // mode 0: ready always 1; 1: ready low for 5 cycles after start; 2: random.
  // spur: fire extra starts (base 0x400) while the load is running.
  task automatic run_image(input logic [AW-1:0] b, input int cnt, input int mode, input bit spur);
    int n;
    int budget;
    base_addr    = b;
    word_cnt     = CW'(cnt);
    start        = 1'b1;
    pe_cfg_ready = (mode == 0);
    tick();
    start  = 1'b0;
    budget = 12 * cnt + 40;
    n      = 0;
    while (m_busy && n < budget) begin
      case (mode)
        0:       pe_cfg_ready = 1'b1;
        1:       pe_cfg_ready = (n >= 5);
        default: pe_cfg_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (spur && $urandom_range(0, 3) == 0) begin
        start     = 1'b1;
        base_addr = 32'h400;
        word_cnt  = CW'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("image_finished", 128'(m_busy), 128'(0));
    check("words_left", 128'(exp_q.size()), 128'(0));
    check("reads_left", 128'(addr_q.size()), 128'(0));
    pe_cfg_ready = 1'b1;
    tick();
  endtask

  // Abort an 8-word load after word 2, then load a fresh 2-word image.
  task automatic reset_mid_load();
    int n;
    base_addr    = 32'h5000;
    word_cnt     = CW'(8);
    start        = 1'b1;
    pe_cfg_ready = 1'b1;
    tick();
    start = 1'b0;
    n     = 0;
    while (hs_done < 3 && n < 60) begin
      tick();
      n++;
    end
    check("reached_word2", 128'(hs_done), 128'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_image(32'h200, 2, 0, 1'b0);
  endtask

  initial begin
    salt         = $urandom;
    rst          = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    word_cnt     = '0;
    pe_cfg_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_image(32'h100, 4, 0, 1'b0);
    run_image(32'h55, 0, 0, 1'b0);
    run_image(32'h2000, 6, 1, 1'b0);
    run_image(32'h3000, 10, 0, 1'b0);
    run_image(32'h103, 5, 2, 1'b1);
    reset_mid_load();
    run_image(32'hFFFF_FFE8, 5, 2, 1'b0);

    for (int k = 0; k < 25; k++) begin
      run_image($urandom, $urandom_range(0, 14), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
